// File: rtl/bloque_campos_bcd_pkg.sv
// rtl/bloque_campos_bcd_pkg.sv - shared states, button indices, default limits and 12 h helper
package bloque_campos_bcd_pkg;

   typedef enum logic [1:0] {
      NORMAL    = 2'd0,
      EDICION   = 2'd1,
      ESCRITURA = 2'd2
   } estado_t;

   localparam int BOT_SUBE = 0;
   localparam int BOT_BAJA = 1;
   localparam int BOT_DER  = 2;
   localparam int BOT_IZQ  = 3;

   // Time fields are {hour, min, sec}; date fields are {year, month, day}
   localparam logic [23:0] LIM_MAX_HORA  = 24'h235959;
   localparam logic [23:0] LIM_MIN_HORA  = 24'h000000;
   localparam logic [23:0] LIM_MAX_FECHA = 24'h991231;
   localparam logic [23:0] LIM_MIN_FECHA = 24'h000101;

   function automatic logic [7:0] hora_12h(input logic [7:0] h);
      logic [7:0] r;
      case (h)
         8'h00:   r = 8'h12;
         8'h13:   r = 8'h01;
         8'h14:   r = 8'h02;
         8'h15:   r = 8'h03;
         8'h16:   r = 8'h04;
         8'h17:   r = 8'h05;
         8'h18:   r = 8'h06;
         8'h19:   r = 8'h07;
         8'h20:   r = 8'h08;
         8'h21:   r = 8'h09;
         8'h22:   r = 8'h10;
         8'h23:   r = 8'h11;
         default: r = h;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bcd_paso.sv
// rtl/bcd_paso.sv - single BCD field step up/down with min/max wrap
module bcd_paso (
   input  logic [7:0] valor,
   input  logic [7:0] lim_max,
   input  logic [7:0] lim_min,
   input  logic       sube,
   input  logic       baja,
   output logic [7:0] siguiente,
   output logic       vuelta
);

   always_comb begin
      siguiente = valor;
      vuelta    = 1'b0;
      if (sube) begin
         if (valor >= lim_max) begin
            siguiente = lim_min;
            vuelta    = 1'b1;
         end else if (valor[3:0] == 4'd9) begin
            siguiente = {valor[7:4] + 4'd1, 4'd0};
         end else begin
            siguiente = {valor[7:4], valor[3:0] + 4'd1};
         end
      end else if (baja) begin
         // Out-of-range values recover to the maximum rather than stepping down
         if (valor <= lim_min || valor > lim_max) begin
            siguiente = lim_max;
            vuelta    = 1'b1;
         end else if (valor[3:0] == 4'd0) begin
            siguiente = {valor[7:4] - 4'd1, 4'd9};
         end else begin
            siguiente = {valor[7:4], valor[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/bloque_campos_bcd.sv
// rtl/bloque_campos_bcd.sv - N-field BCD time/date counter with edit mode and RTC write-back
module bloque_campos_bcd
   import bloque_campos_bcd_pkg::*;
#(
   parameter int                      N_CAMPOS   = 3,
   parameter int                      ANCHO_POS  = 2,
   parameter logic [8*N_CAMPOS-1:0]   LIM_MAX    = 24'h235959,
   parameter logic [8*N_CAMPOS-1:0]   LIM_MIN    = 24'h000000,
   parameter int                      CAMPO_HORA = 2
) (
   input  logic                    reloj,
   input  logic                    resetM,
   input  logic                    F_H,
   input  logic                    READ,
   input  logic                    IN_valido,
   input  logic [8*N_CAMPOS-1:0]   IN_campos,
   input  logic                    tick,
   input  logic                    enable_edicion,
   input  logic [3:0]              IN_bot,
   input  logic                    escribir_ack,
   output logic [8*N_CAMPOS-1:0]   OUT_campos,
   output logic                    OUT_pm,
   output logic [ANCHO_POS-1:0]    Contador_pos,
   output logic                    escribir,
   output logic                    desborde
);

   localparam logic [ANCHO_POS-1:0] POS_ULTIMA = ANCHO_POS'(N_CAMPOS - 1);

   estado_t                 estado;
   logic [8*N_CAMPOS-1:0]   campos;
   logic [8*N_CAMPOS-1:0]   campos_sig;
   logic [ANCHO_POS-1:0]    pos;
   logic                    modificado;
   logic [3:0]              bot_prev;
   logic [3:0]              flanco;
   logic                    carga, tick_normal, desborde_sig;
   logic                    accion_sube, accion_baja, accion_der, accion_izq;

   assign carga       = IN_valido & READ;
   assign tick_normal = (estado == NORMAL) & tick & ~carga;

   // Only the highest-priority new press acts
   assign flanco      = IN_bot & ~bot_prev;
   assign accion_sube = flanco[BOT_SUBE];
   assign accion_baja = flanco[BOT_BAJA] & ~flanco[BOT_SUBE];
   assign accion_der  = flanco[BOT_DER]  & ~flanco[BOT_SUBE] & ~flanco[BOT_BAJA];
   assign accion_izq  = flanco[BOT_IZQ]  & ~flanco[BOT_SUBE] & ~flanco[BOT_BAJA] & ~flanco[BOT_DER];

   genvar i;
   for (i = 0; i < N_CAMPOS; i++) begin : g_campo
      logic       entrada, vuelta, sel;
      logic [7:0] siguiente;
      if (i == 0) begin : g_primero
         assign entrada = tick_normal;
      end else begin : g_resto
         assign entrada = g_campo[i-1].entrada & g_campo[i-1].vuelta;
      end
      assign sel = (estado == EDICION) && (pos == ANCHO_POS'(i));
      bcd_paso u_paso (
         .valor     (campos[8*i +: 8]),
         .lim_max   (LIM_MAX[8*i +: 8]),
         .lim_min   (LIM_MIN[8*i +: 8]),
         .sube      (entrada | (sel & accion_sube)),
         .baja      (sel & accion_baja),
         .siguiente (siguiente),
         .vuelta    (vuelta)
      );
      assign campos_sig[8*i +: 8] = siguiente;
   end

   assign desborde_sig = g_campo[N_CAMPOS-1].entrada & g_campo[N_CAMPOS-1].vuelta;

   always_ff @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         estado     <= NORMAL;
         campos     <= LIM_MIN;
         pos        <= '0;
         modificado <= 1'b0;
         bot_prev   <= 4'b0000;
         escribir   <= 1'b0;
         desborde   <= 1'b0;
      end else begin
         bot_prev <= IN_bot;
         desborde <= 1'b0;
         case (estado)
            NORMAL: begin
               if (carga) begin
                  campos <= IN_campos;
               end else begin
                  campos   <= campos_sig;
                  desborde <= desborde_sig;
               end
               if (enable_edicion) begin
                  estado     <= EDICION;
                  pos        <= '0;
                  modificado <= 1'b0;
               end
            end
            EDICION: begin
               campos <= campos_sig;
               if (accion_sube | accion_baja)
                  modificado <= 1'b1;
               if (accion_der)
                  pos <= (pos == POS_ULTIMA) ? '0 : pos + 1'b1;
               else if (accion_izq)
                  pos <= (pos == '0) ? POS_ULTIMA : pos - 1'b1;
               if (!enable_edicion) begin
                  estado   <= modificado ? ESCRITURA : NORMAL;
                  escribir <= modificado;
               end
            end
            ESCRITURA: begin
               if (escribir_ack) begin
                  estado   <= NORMAL;
                  escribir <= 1'b0;
               end
            end
            default: begin
               estado   <= NORMAL;
               escribir <= 1'b0;
            end
         endcase
      end
   end

   assign Contador_pos = pos;

   // 12 h conversion is display-only; storage always holds 00-23
   if (CAMPO_HORA < N_CAMPOS) begin : g_12h
      always_comb begin
         OUT_campos = campos;
         if (!F_H)
            OUT_campos[8*CAMPO_HORA +: 8] = hora_12h(campos[8*CAMPO_HORA +: 8]);
      end
      assign OUT_pm = ~F_H & (campos[8*CAMPO_HORA +: 8] >= 8'h12);
   end else begin : g_24h
      assign OUT_campos = campos;
      assign OUT_pm     = 1'b0;
   end

endmodule

// File: tb/tb_bloque_campos_bcd.sv
// tb/tb_bloque_campos_bcd.sv - self-checking bench for bloque_campos_bcd
module tb_bloque_campos_bcd;

   logic        reloj = 1'b0;
   logic        resetM, F_H, READ, IN_valido, tick, enable_edicion, escribir_ack;
   logic [23:0] IN_campos, OUT_campos;
   logic [3:0]  IN_bot;
   logic        OUT_pm, escribir, desborde;
   logic [1:0]  Contador_pos;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] campos;
      logic        f_h;
      logic [23:0] exp_out;
      logic        exp_pm;
   } vec_t;

   vec_t tabla [7];

   bloque_campos_bcd dut (
      .reloj          (reloj),
      .resetM         (resetM),
      .F_H            (F_H),
      .READ           (READ),
      .IN_valido      (IN_valido),
      .IN_campos      (IN_campos),
      .tick           (tick),
      .enable_edicion (enable_edicion),
      .IN_bot         (IN_bot),
      .escribir_ack   (escribir_ack),
      .OUT_campos     (OUT_campos),
      .OUT_pm         (OUT_pm),
      .Contador_pos   (Contador_pos),
      .escribir       (escribir),
      .desborde       (desborde)
   );

   always #5 reloj = ~reloj;

   task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nombre, act, exp);
      end
   endtask

   task automatic paso();
      @(posedge reloj);
      #1;
   endtask

   task automatic boton(input logic [3:0] b);
      IN_bot = b;
      paso();
      IN_bot = 4'b0000;
      paso();
   endtask

   task automatic cargar(input logic [23:0] v);
      IN_campos = v;
      IN_valido = 1'b1;
      READ      = 1'b1;
      paso();
      IN_valido = 1'b0;
      READ      = 1'b0;
   endtask

   // Reference: time of day as seconds since midnight, shown as BCD hh:mm:ss
   function automatic logic [23:0] a_bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   initial begin
      int  s, nuevo;
      bit  vuelta_ref, es_carga;

      tabla[0] = '{24'h000000, 1'b0, 24'h120000, 1'b0};
      tabla[1] = '{24'h130000, 1'b0, 24'h010000, 1'b1};
      tabla[2] = '{24'h230000, 1'b0, 24'h110000, 1'b1};
      tabla[3] = '{24'h230000, 1'b1, 24'h230000, 1'b0};
      tabla[4] = '{24'h120000, 1'b0, 24'h120000, 1'b1};
      tabla[5] = '{24'h110000, 1'b0, 24'h110000, 1'b0};
      tabla[6] = '{24'h200000, 1'b0, 24'h080000, 1'b1};

      resetM = 1'b0; F_H = 1'b1; READ = 1'b0; IN_valido = 1'b0; IN_campos = '0;
      tick = 1'b0; enable_edicion = 1'b0; IN_bot = 4'b0000; escribir_ack = 1'b0;
      repeat (3) paso();
      chk("reset_campos", OUT_campos, 24'h000000);
      chk("reset_pos", Contador_pos, 2'd0);
      chk("reset_escribir", escribir, 1'b0);
      chk("reset_desborde", desborde, 1'b0);
      @(negedge reloj);
      resetM = 1'b1;
      paso();

      // Load then roll over the whole day
      cargar(24'h235958);
      chk("carga", OUT_campos, 24'h235958);
      tick = 1'b1;
      paso();
      chk("tick_1", OUT_campos, 24'h235959);
      chk("desborde_antes", desborde, 1'b0);
      paso();
      tick = 1'b0;
      chk("tick_vuelta", OUT_campos, 24'h000000);
      chk("desborde_pulso", desborde, 1'b1);
      paso();
      chk("desborde_un_ciclo", desborde, 1'b0);

      // Edit navigation
      cargar(24'h105930);
      enable_edicion = 1'b1;
      paso();
      chk("edic_pos0", Contador_pos, 2'd0);
      boton(4'b0100);
      chk("der_pos1", Contador_pos, 2'd1);
      IN_bot = 4'b0001;
      repeat (3) paso();
      IN_bot = 4'b0000;
      paso();
      chk("sube_max_a_min_una_vez", OUT_campos, 24'h100030);
      boton(4'b0010);
      chk("baja_min_a_max", OUT_campos, 24'h105930);
      tick = 1'b1;
      boton(4'b1000);
      boton(4'b1000);
      tick = 1'b0;
      chk("izq_dos_pos2", Contador_pos, 2'd2);
      chk("tick_ignorado_edic", OUT_campos, 24'h105930);
      boton(4'b0101);
      chk("sube_der_campos", OUT_campos, 24'h115930);
      chk("sube_der_pos", Contador_pos, 2'd2);

      // Write-back with delayed ack
      enable_edicion = 1'b0;
      paso();
      chk("escribir_sube", escribir, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick      = 1'b1;
         IN_valido = 1'b1;
         READ      = 1'b1;
         IN_campos = 24'h010203;
         paso();
         chk("escribir_mantenido", escribir, 1'b1);
         chk("campos_congelados", OUT_campos, 24'h115930);
      end
      tick = 1'b0; IN_valido = 1'b0; READ = 1'b0;
      escribir_ack = 1'b1;
      paso();
      escribir_ack = 1'b0;
      chk("escribir_ack", escribir, 1'b0);
      tick = 1'b1;
      paso();
      tick = 1'b0;
      chk("normal_tras_ack", OUT_campos, 24'h115931);
      enable_edicion = 1'b1;
      paso();
      enable_edicion = 1'b0;
      paso();
      chk("sin_cambio_no_escribe", escribir, 1'b0);
      paso();
      chk("sin_cambio_no_escribe_2", escribir, 1'b0);

      // 12 h display table
      foreach (tabla[k]) begin
         F_H = tabla[k].f_h;
         cargar(tabla[k].campos);
         chk($sformatf("hora12_out_%0d", k), OUT_campos, tabla[k].exp_out);
         chk($sformatf("hora12_pm_%0d", k), OUT_pm, tabla[k].exp_pm);
      end
      F_H = 1'b1;

      // Asynchronous reset while a write-back is pending
      cargar(24'h000000);
      enable_edicion = 1'b1;
      paso();
      boton(4'b0001);
      enable_edicion = 1'b0;
      paso();
      chk("escritura_pendiente", escribir, 1'b1);
      #2;
      resetM = 1'b0;
      #1;
      chk("reset_async_escribir", escribir, 1'b0);
      chk("reset_async_campos", OUT_campos, 24'h000000);
      @(negedge reloj);
      resetM = 1'b1;
      escribir_ack = 1'b1;
      paso();
      escribir_ack = 1'b0;
      chk("ack_tras_reset", escribir, 1'b0);
      tick = 1'b1;
      paso();
      tick = 1'b0;
      chk("normal_tras_reset", OUT_campos, 24'h000001);

      // Randomized loads/ticks against the seconds-of-day model
      s = 1;
      for (int k = 0; k < 300; k++) begin
         es_carga = ($urandom_range(0, 7) == 0);
         tick     = 1'(($urandom_range(0, 1)));
         if (es_carga) begin
            nuevo     = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 86399))
                                                    : int'($urandom_range(86395, 86399));
            IN_campos = a_bcd(nuevo);
            IN_valido = 1'b1;
            READ      = 1'b1;
         end else begin
            nuevo     = 0;
            IN_campos = 24'($urandom);
            IN_valido = 1'(($urandom_range(0, 1)));
            READ      = 1'b0;
         end
         paso();
         vuelta_ref = 1'b0;
         if (es_carga) begin
            s = nuevo;
         end else if (tick) begin
            s = s + 1;
            if (s == 86400) begin
               s = 0;
               vuelta_ref = 1'b1;
            end
         end
         chk("rand_campos", OUT_campos, a_bcd(s));
         chk("rand_desborde", desborde, vuelta_ref);
      end
      tick = 1'b0; IN_valido = 1'b0; READ = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
